uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//   Shares one UART transmitter among NUM_REQ byte producers.
//   Requests are granted round-robin. The arbiter latches the winner's byte,
//   pulses the transmitter start and tracks the frame via tx_busy.
//   It then enforces an inter-frame idle gap before the next grant.
//   Sits between producer logic and the tx block, on the 1 MHz system clock.
// PARAMETERS
//   NUM_REQ        4     number of requesters (>=2)
//   DATA_W         8     byte width
//   CLKS_PER_BIT   53    tx bit period in clk cycles
//   GAP_CLKS       53    idle clk cycles after each frame (0 = no gap)
//   START_TIMEOUT  106   clks to wait for tx_busy rise before abort
// PORTS
//   clk        in   1                 system clock, rising edge
//   rst_n      in   1                 async active-low reset
//   req        in   NUM_REQ           request per requester, level
//   req_data   in   NUM_REQ*DATA_W    byte of requester i at [i*DATA_W +: DATA_W]
//   ack        out  NUM_REQ           1-clk pulse: requester i byte captured
//   done       out  NUM_REQ           1-clk pulse: requester i frame finished
//   grant_id   out  $clog2(NUM_REQ)   index of current/last granted requester
//   tx_start   out  1                 1-clk start pulse to transmitter
//   tx_data    out  DATA_W            byte to transmitter
//   tx_busy    in   1                 transmitter frame in progress
//   busy       out  1                 arbiter not in IDLE
//   err        out  1                 sticky: start timeout occurred
// BEHAVIOUR
// - Reset (async, immediate):
//   - State IDLE.
//   - All outputs 0, including tx_data, grant_id and err.
//   - rr pointer = NUM_REQ-1, so requester 0 wins first.
// - FSM states: IDLE, START, WAIT_BUSY, WAIT_DONE, GAP.
// - IDLE, any req set:
//   - Winner = first set bit searching from ptr+1 upward, wrapping.
//   - On that edge:
//     - tx_data <= winner's byte.
//     - grant_id <= winner.
//     - ptr <= winner.
//     - ack[winner] = 1 for the next cycle.
//     - Go to START.
//   - Latency: req seen -> ack 1 clk -> tx_start 2nd clk.
// - START: tx_start=1 for exactly one clk; clear counter; go to WAIT_BUSY.
// - WAIT_BUSY:
//   - tx_busy=1 -> WAIT_DONE.
//   - Else count up. At START_TIMEOUT clks: set err=1, no done pulse, go to GAP.
// - WAIT_DONE: on tx_busy=0, done[grant_id]=1 for one clk; go to GAP.
// - GAP: count GAP_CLKS clks, then go to IDLE. GAP_CLKS=0 goes straight to IDLE.
// - req is sampled only in IDLE.
//   - Requests raised outside IDLE wait for the next arbitration.
//   - A req dropped before arbitration is never served.
// - A requester holding req high after its ack is treated as a new request.
//   It is served again only after every other pending requester (fairness).
// - tx_data and grant_id hold stable from START until the next arbitration.
// - busy = (state != IDLE).
// - ack and done are one-hot or zero, never multi-bit.
// - err stays set until rst_n; later requests are still served normally.
// - Reset mid-frame:
//   - Immediate return to IDLE.
//   - tx_start is dropped and no done is issued.
//   - A frame already started in the transmitter is ignored.
// TESTING
// - Reset: assert rst_n=0 while in WAIT_DONE -> all outputs 0 and busy=0 immediately;
//   next request goes to req0 if several are pending.
// - Single request: req[2]=1, byte 0x14 ->
//   - ack=4'b0100 one clk later; tx_start one clk after, with tx_data=0x14.
//   - done=4'b0100 one clk after tx_busy falls.
//   - busy=0 after GAP_CLKS.
// - Contention: req=4'b1111, bytes 0xA0..0xA3 -> tx_data sequence 0xA0,0xA1,0xA2,0xA3;
//   each frame separated by >=GAP_CLKS idle.
// - Fairness: req[0] held high, req[1] pulsed after each done ->
//   grants alternate 0,1,0,1; req[0] never wins twice while req[1] pending.
// - Timeout: tx_busy tied 0, req[3]=1 ->
//   - err=1 exactly START_TIMEOUT clks after tx_start.
//   - No done pulse; a later req[1] is still served with tx_start pulsed.
// - Wrap: ptr at 3, req=4'b1001 -> req0 granted before req3.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Producer handshake and transmitter-side signals of the shared UART transmit arbiter.
// slave = arbiter view, master = producers/transmitter view.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        ack;
  logic [NUM_REQ-1:0]        done;
  logic [ID_W-1:0]           grant_id;
  logic                      tx_start;
  logic [DATA_W-1:0]         tx_data;
  logic                      tx_busy;
  logic                      busy;
  logic                      err;

  modport slave (
    input  req, req_data, tx_busy,
    output ack, done, grant_id, tx_start, tx_data, busy, err
  );

  modport master (
    output req, req_data, tx_busy,
    input  ack, done, grant_id, tx_start, tx_data, busy, err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte producers,
// with a start-timeout watchdog and an enforced idle gap between frames.
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int DATA_W        = 8,
  parameter int CLKS_PER_BIT  = 53,
  parameter int GAP_CLKS      = CLKS_PER_BIT,
  parameter int START_TIMEOUT = 2 * CLKS_PER_BIT
) (
  input  logic             clk,
  input  logic             rst_n,
  uart_tx_arbiter_if.slave bus
);
  localparam int ID_W    = $clog2(NUM_REQ);
  localparam int CNT_MAX = (START_TIMEOUT > GAP_CLKS) ? START_TIMEOUT : GAP_CLKS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'((START_TIMEOUT > 0) ? START_TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CLKS > 0) ? GAP_CLKS - 1 : 0);

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_BUSY,
    WAIT_DONE,
    GAP
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [ID_W-1:0]     grant_q, grant_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic [NUM_REQ-1:0]  done_q, done_d;
  logic                start_q, start_d;
  logic                err_q, err_d;

  logic [DATA_W-1:0]   req_bytes [NUM_REQ];
  logic                found;
  logic [ID_W-1:0]     win;
  logic [ID_W-1:0]     idx;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign req_bytes[gi] = bus.req_data[gi*DATA_W +: DATA_W];
  end

  // Search starts just after the last winner so a re-raised request goes to the back.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = ID_W'((int'(ptr_q) + i) % NUM_REQ);
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    data_d  = data_q;
    ack_d   = '0;
    done_d  = '0;
    start_d = 1'b0;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          data_d     = req_bytes[win];
          grant_d    = win;
          ptr_d      = win;
          ack_d[win] = 1'b1;
          state_d    = START;
        end
      end
      START: begin
        start_d = 1'b1;
        cnt_d   = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (bus.tx_busy) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == TO_LAST) begin
          // Transmitter never acknowledged the start: flag it and skip the done pulse.
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = (GAP_CLKS == 0) ? IDLE : GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!bus.tx_busy) begin
          done_d[grant_q] = 1'b1;
          cnt_d           = '0;
          state_d         = (GAP_CLKS == 0) ? IDLE : GAP;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= ID_W'(NUM_REQ - 1);
      grant_q <= '0;
      data_q  <= '0;
      ack_q   <= '0;
      done_q  <= '0;
      start_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      start_q <= start_d;
      err_q   <= err_d;
    end
  end

  assign bus.ack      = ack_q;
  assign bus.done     = done_q;
  assign bus.grant_id = grant_q;
  assign bus.tx_start = start_q;
  assign bus.tx_data  = data_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.err      = err_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: reset, single grant, contention, fairness,
// start timeout, pointer wrap and reset in the middle of a frame.
module tb_uart_tx_arbiter;
  localparam int GAP_CLKS = 53;

  logic clk;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  uart_tx_arbiter_if #(.NUM_REQ(4), .DATA_W(8)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ      (4),
    .DATA_W       (8),
    .CLKS_PER_BIT (53),
    .GAP_CLKS     (GAP_CLKS),
    .START_TIMEOUT(106)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_start(output bit ok, output int cyc);
    ok  = 1'b0;
    cyc = 0;
    while (!ok && cyc < 400) begin
      tick();
      cyc++;
      if (bus.tx_start === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic wait_idle(output bit ok);
    int c;
    ok = 1'b0;
    c  = 0;
    while (!ok && c < 400) begin
      tick();
      c++;
      if (bus.busy === 1'b0) ok = 1'b1;
    end
  endtask

  task automatic serve(input int len);
    bus.tx_busy = 1'b1;
    tick(len);
    bus.tx_busy = 1'b0;
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    bus.req      = '0;
    bus.req_data = '0;
    bus.tx_busy  = 1'b0;
    tick(2);
    n_tests++; if ({bus.ack, bus.done, bus.tx_start, bus.busy, bus.err} !== 11'd0) begin n_fail++; $display("FAIL reset_ctrl: got %b want 0", {bus.ack, bus.done, bus.tx_start, bus.busy, bus.err}); end
    n_tests++; if (bus.tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %h want 00", bus.tx_data); end
    n_tests++; if (bus.grant_id !== 2'd0) begin n_fail++; $display("FAIL reset_grant: got %0d want 0", bus.grant_id); end
    rst_n = 1'b1;
    tick(2);
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy: got %b want 0", bus.busy); end
    $display("[TB] test_reset done");
  endtask

  task automatic test_contention();
    bit ok;
    int cyc;
    logic [7:0] exp_b;
    logic [3:0] exp_d;
    bus.req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    bus.req      = 4'b1111;
    for (int f = 0; f < 4; f++) begin
      exp_b = 8'hA0 + 8'(f);
      exp_d = 4'(1 << f);
      wait_start(ok, cyc);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL cont_start%0d: no tx_start within bound", f); end
      n_tests++; if (bus.tx_data !== exp_b) begin n_fail++; $display("FAIL cont_data%0d: got %h want %h", f, bus.tx_data, exp_b); end
      if (f > 0) begin
        n_tests++; if (cyc < GAP_CLKS) begin n_fail++; $display("FAIL cont_gap%0d: got %0d clks want >= %0d", f, cyc, GAP_CLKS); end
      end
      if (f == 3) bus.req = '0;
      serve(10);
      tick();
      n_tests++; if (bus.done !== exp_d) begin n_fail++; $display("FAIL cont_done%0d: got %b want %b", f, bus.done, exp_d); end
      $display("[TB] contention frame %0d data=%h gap=%0d", f, bus.tx_data, cyc);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    int cyc;
    wait_idle(ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL wrap_idle: busy never cleared"); end
    bus.req_data = {8'h33, 8'h00, 8'h00, 8'h11};
    bus.req      = 4'b1001;
    wait_start(ok, cyc);
    n_tests++; if (bus.grant_id !== 2'd0 || bus.tx_data !== 8'h11) begin n_fail++; $display("FAIL wrap_first: got id %0d data %h want id 0 data 11", bus.grant_id, bus.tx_data); end
    serve(8);
    tick();
    n_tests++; if (bus.done !== 4'b0001) begin n_fail++; $display("FAIL wrap_done0: got %b want 0001", bus.done); end
    wait_start(ok, cyc);
    n_tests++; if (bus.grant_id !== 2'd3 || bus.tx_data !== 8'h33) begin n_fail++; $display("FAIL wrap_second: got id %0d data %h want id 3 data 33", bus.grant_id, bus.tx_data); end
    bus.req = '0;
    serve(8);
    tick();
    n_tests++; if (bus.done !== 4'b1000) begin n_fail++; $display("FAIL wrap_done3: got %b want 1000", bus.done); end
    $display("[TB] test_wrap done");
  endtask

  task automatic test_single();
    bit ok;
    wait_idle(ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL single_idle: busy never cleared"); end
    bus.req_data = {8'h00, 8'h14, 8'h00, 8'h00};
    bus.req      = 4'b0100;
    tick();
    n_tests++; if (bus.ack !== 4'b0100) begin n_fail++; $display("FAIL single_ack: got %b want 0100", bus.ack); end
    n_tests++; if (bus.tx_start !== 1'b0) begin n_fail++; $display("FAIL single_early_start: got %b want 0", bus.tx_start); end
    bus.req = '0;
    tick();
    n_tests++; if (bus.tx_start !== 1'b1) begin n_fail++; $display("FAIL single_start: got %b want 1", bus.tx_start); end
    n_tests++; if (bus.tx_data !== 8'h14) begin n_fail++; $display("FAIL single_data: got %h want 14", bus.tx_data); end
    n_tests++; if (bus.grant_id !== 2'd2) begin n_fail++; $display("FAIL single_grant: got %0d want 2", bus.grant_id); end
    n_tests++; if (bus.ack !== 4'b0000) begin n_fail++; $display("FAIL single_ack_clear: got %b want 0000", bus.ack); end
    bus.tx_busy = 1'b1;
    tick();
    n_tests++; if (bus.tx_start !== 1'b0 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL single_start_pulse: got start %b busy %b want 0 1", bus.tx_start, bus.busy); end
    tick(5);
    bus.tx_busy = 1'b0;
    tick();
    n_tests++; if (bus.done !== 4'b0100) begin n_fail++; $display("FAIL single_done: got %b want 0100", bus.done); end
    tick();
    n_tests++; if (bus.done !== 4'b0000) begin n_fail++; $display("FAIL single_done_pulse: got %b want 0000", bus.done); end
    tick(51);
    n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL single_gap_end: got busy %b want 1", bus.busy); end
    tick();
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL single_gap_idle: got busy %b want 0", bus.busy); end
    $display("[TB] test_single done");
  endtask

  task automatic test_fairness();
    bit ok;
    int cyc;
    logic [1:0] exp_id;
    wait_idle(ok);
    bus.req_data = {8'h00, 8'h00, 8'hF1, 8'hF0};
    bus.req      = 4'b0011;
    for (int f = 0; f < 4; f++) begin
      exp_id = 2'(f % 2);
      wait_start(ok, cyc);
      n_tests++; if (!ok || bus.grant_id !== exp_id) begin n_fail++; $display("FAIL fair_grant%0d: got %0d want %0d", f, bus.grant_id, exp_id); end
      if (exp_id == 2'd1) bus.req[1] = 1'b0;
      if (f == 3) bus.req = '0;
      serve(6);
      tick();
      if (exp_id == 2'd1 && f < 3) bus.req[1] = 1'b1;
      $display("[TB] fairness frame %0d grant=%0d", f, bus.grant_id);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int cyc;
    bit saw_done;
    wait_idle(ok);
    bus.req_data = {8'h5A, 8'h00, 8'h3C, 8'h00};
    bus.tx_busy  = 1'b0;
    bus.req      = 4'b1000;
    wait_start(ok, cyc);
    n_tests++; if (!ok || bus.grant_id !== 2'd3) begin n_fail++; $display("FAIL to_grant: got %0d want 3", bus.grant_id); end
    bus.req  = '0;
    saw_done = 1'b0;
    for (int i = 1; i <= 106; i++) begin
      tick();
      if (bus.done !== 4'b0000) saw_done = 1'b1;
      if (i == 105) begin
        n_tests++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL to_err_early: got %b want 0", bus.err); end
      end
      if (i == 106) begin
        n_tests++; if (bus.err !== 1'b1) begin n_fail++; $display("FAIL to_err: got %b want 1", bus.err); end
      end
    end
    n_tests++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL to_no_done: got done pulse want none"); end
    bus.req = 4'b0010;
    wait_start(ok, cyc);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL to_later_start: no tx_start within bound"); end
    n_tests++; if (bus.tx_data !== 8'h3C || bus.grant_id !== 2'd1) begin n_fail++; $display("FAIL to_later_grant: got id %0d data %h want id 1 data 3c", bus.grant_id, bus.tx_data); end
    n_tests++; if (bus.err !== 1'b1) begin n_fail++; $display("FAIL to_err_sticky: got %b want 1", bus.err); end
    bus.req = '0;
    serve(6);
    tick();
    n_tests++; if (bus.done !== 4'b0010) begin n_fail++; $display("FAIL to_later_done: got %b want 0010", bus.done); end
    $display("[TB] test_timeout done");
  endtask

  task automatic test_reset_midframe();
    bit ok;
    int cyc;
    wait_idle(ok);
    bus.req_data = {8'h33, 8'h77, 8'h00, 8'h11};
    bus.req      = 4'b0100;
    wait_start(ok, cyc);
    n_tests++; if (!ok || bus.grant_id !== 2'd2) begin n_fail++; $display("FAIL mid_grant: got %0d want 2", bus.grant_id); end
    bus.req = '0;
    bus.tx_busy = 1'b1;
    tick(3);
    n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy: got %b want 1", bus.busy); end
    bus.req = 4'b1001;
    rst_n   = 1'b0;
    #1;
    n_tests++; if ({bus.ack, bus.done, bus.tx_start, bus.busy, bus.err} !== 11'd0) begin n_fail++; $display("FAIL mid_reset_ctrl: got %b want 0", {bus.ack, bus.done, bus.tx_start, bus.busy, bus.err}); end
    n_tests++; if (bus.tx_data !== 8'h00 || bus.grant_id !== 2'd0) begin n_fail++; $display("FAIL mid_reset_data: got id %0d data %h want 0 00", bus.grant_id, bus.tx_data); end
    bus.tx_busy = 1'b0;
    tick();
    rst_n = 1'b1;
    wait_start(ok, cyc);
    n_tests++; if (!ok || bus.grant_id !== 2'd0 || bus.tx_data !== 8'h11) begin n_fail++; $display("FAIL mid_after_grant: got id %0d data %h want id 0 data 11", bus.grant_id, bus.tx_data); end
    bus.req = '0;
    serve(4);
    tick();
    n_tests++; if (bus.done !== 4'b0001) begin n_fail++; $display("FAIL mid_after_done: got %b want 0001", bus.done); end
    $display("[TB] test_reset_midframe done");
  endtask

  initial begin
    test_reset();
    test_contention();
    test_wrap();
    test_single();
    test_fairness();
    test_timeout();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
